// File: rtl/param_matrix_mult_stream_if.sv
// Element stream into, and C-element stream out of, the NxN matrix multiplier.
// Latency: none, this is wiring only.
// Backpressure: in_ready is driven by the multiplier, out_ready by the downstream consumer.
interface param_matrix_mult_stream_if #(
    parameter int DATA_W = 8,
    parameter int OUT_W  = 8
);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [OUT_W-1:0]  out_data;
    logic              out_last;

    // master: the environment around the block (framer upstream, transmitter downstream)
    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_last
    );

    // slave: the multiplier itself
    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_last
    );
endinterface

// File: rtl/param_matrix_mult_stream.sv
// NxN unsigned matrix multiply C = A x B; A then B stream in row-major, C streams out row-major.
// Latency: last element accepted at edge T -> first C element valid after edge T+N^3+1.
// Backpressure: in_ready only in LOAD; C element and out_last hold while out_ready is low.
module param_matrix_mult_stream #(
    parameter int N        = 3,
    parameter int DATA_W   = 8,
    parameter int OUT_W    = 8,
    parameter int SATURATE = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    param_matrix_mult_stream_if.slave bus,
    output logic                     busy,
    output logic                     ovf
);
    // Sum of N products of two DATA_W values fits without wrapping.
    localparam int ACC_W = 2*DATA_W + $clog2(N);
    localparam int CW    = (N > 1) ? $clog2(N) : 1;
    // Comparison width wide enough for both the accumulator and the output limit.
    localparam int CMP_W = (ACC_W > OUT_W) ? ACC_W : OUT_W;
    localparam logic [CW-1:0]    LAST    = CW'(N-1);
    localparam logic [CMP_W-1:0] OUT_MAX = CMP_W'({OUT_W{1'b1}});

    typedef enum logic [1:0] {
        S_LOAD    = 2'd0,
        S_COMPUTE = 2'd1,
        S_OUTPUT  = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [DATA_W-1:0] a_mem [N][N];
    logic [DATA_W-1:0] b_mem [N][N];
    logic [OUT_W-1:0]  c_mem [N][N];

    // Load position: ld_sel=0 fills A, ld_sel=1 fills B.
    logic          ld_sel;
    logic [CW-1:0] ld_r, ld_c;

    // MAC issue indices, i outer, j middle, k inner.
    logic [CW-1:0] mi, mj, mk;
    logic          issue_done;

    // Registered product stage: the multiply is split from the accumulate add,
    // which is where the extra cycle of latency beyond N^3 comes from.
    logic [2*DATA_W-1:0] prod_q;
    logic                prod_vld_q;
    logic                prod_endk_q;
    logic                prod_final_q;
    logic [CW-1:0]       prod_i_q, prod_j_q;

    logic [ACC_W-1:0] acc_q;
    logic [ACC_W-1:0] acc_sum;
    logic [CMP_W-1:0] acc_ext;
    logic             acc_over;
    logic [OUT_W-1:0] c_val;

    logic [CW-1:0] out_r, out_c;

    logic in_acc, ld_end, out_acc, out_end, issue_en, issue_end;

    assign in_acc    = bus.in_valid && bus.in_ready;
    assign ld_end    = ld_sel && (ld_r == LAST) && (ld_c == LAST);
    assign out_acc   = bus.out_valid && bus.out_ready;
    assign out_end   = out_acc && (out_r == LAST) && (out_c == LAST);
    assign issue_en  = (state_q == S_COMPUTE) && !issue_done;
    assign issue_end = (mi == LAST) && (mj == LAST) && (mk == LAST);

    // Next-state and handshake outputs, all derived from the current state.
    always_comb begin
        state_d       = state_q;
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        bus.out_last  = 1'b0;
        busy          = 1'b0;
        case (state_q)
            S_LOAD: begin
                bus.in_ready = 1'b1;
                if (in_acc && ld_end) state_d = S_COMPUTE;
            end
            S_COMPUTE: begin
                busy = 1'b1;
                if (prod_vld_q && prod_final_q) state_d = S_OUTPUT;
            end
            S_OUTPUT: begin
                busy          = 1'b1;
                bus.out_valid = 1'b1;
                bus.out_last  = (out_r == LAST) && (out_c == LAST);
                if (out_end) state_d = S_LOAD;
            end
            default: state_d = S_LOAD;
        endcase
    end

    assign bus.out_data = c_mem[out_r][out_c];

    // Accumulate add and the saturate/truncate decision for a finished dot product.
    always_comb begin
        acc_sum  = acc_q + ACC_W'(prod_q);
        acc_ext  = CMP_W'(acc_sum);
        acc_over = acc_ext > OUT_MAX;
        c_val    = acc_ext[OUT_W-1:0];
        if (acc_over && (SATURATE != 0)) c_val = {OUT_W{1'b1}};
    end

    // Control state: FSM register, counters, accumulator and the sticky overflow flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_LOAD;
            ld_sel     <= 1'b0;
            ld_r       <= '0;
            ld_c       <= '0;
            mi         <= '0;
            mj         <= '0;
            mk         <= '0;
            issue_done <= 1'b0;
            prod_vld_q <= 1'b0;
            acc_q      <= '0;
            out_r      <= '0;
            out_c      <= '0;
            ovf        <= 1'b0;
        end else begin
            state_q    <= state_d;
            prod_vld_q <= issue_en;

            if (in_acc) begin
                if (!ld_sel && (ld_r == '0) && (ld_c == '0)) ovf <= 1'b0;
                if (ld_c == LAST) begin
                    ld_c <= '0;
                    if (ld_r == LAST) begin
                        ld_r   <= '0;
                        ld_sel <= ~ld_sel;
                    end else begin
                        ld_r <= ld_r + CW'(1);
                    end
                end else begin
                    ld_c <= ld_c + CW'(1);
                end
            end

            if (issue_en) begin
                if (issue_end) issue_done <= 1'b1;
                if (mk == LAST) begin
                    mk <= '0;
                    if (mj == LAST) begin
                        mj <= '0;
                        mi <= (mi == LAST) ? '0 : mi + CW'(1);
                    end else begin
                        mj <= mj + CW'(1);
                    end
                end else begin
                    mk <= mk + CW'(1);
                end
            end else if (state_q != S_COMPUTE) begin
                issue_done <= 1'b0;
            end

            if (prod_vld_q) begin
                if (prod_endk_q) begin
                    acc_q <= '0;
                    if (acc_over) ovf <= 1'b1;
                end else begin
                    acc_q <= acc_sum;
                end
            end

            if (out_acc) begin
                if (out_c == LAST) begin
                    out_c <= '0;
                    out_r <= (out_r == LAST) ? '0 : out_r + CW'(1);
                end else begin
                    out_c <= out_c + CW'(1);
                end
            end
        end
    end

    // Datapath storage: matrix buffers and the product pipeline stage need no reset.
    always_ff @(posedge clk) begin
        if (in_acc) begin
            if (!ld_sel) a_mem[ld_r][ld_c] <= bus.in_data;
            else         b_mem[ld_r][ld_c] <= bus.in_data;
        end
        prod_q       <= a_mem[mi][mk] * b_mem[mk][mj];
        prod_endk_q  <= (mk == LAST);
        prod_final_q <= issue_end;
        prod_i_q     <= mi;
        prod_j_q     <= mj;
        if (prod_vld_q && prod_endk_q) c_mem[prod_i_q][prod_j_q] <= c_val;
    end
endmodule

// File: tb/tb_param_matrix_mult_stream.sv
// Bench for the streaming matrix multiplier: three instances (N=3 saturating, N=3 truncating, N=4 16-bit out).
// Latency: checks first C valid exactly N^3+1 edges after the last accepted element.
// Backpressure: drives random out_ready and input gaps; results compared against plain dot products.
`timescale 1ns/1ps
module tb_param_matrix_mult_stream;
    logic       clk       = 1'b0;
    logic       rst       = 1'b1;
    logic       sel       = 1'b0;   // 0: the two N=3 instances, 1: the N=4 instance
    logic       in_valid  = 1'b0;
    logic [7:0] in_data   = 8'd0;
    logic       out_ready = 1'b0;
    logic       busy_s, busy_t, busy_w, ovf_s, ovf_t, ovf_w;
    logic       cur_in_ready, cur_out_valid;
    int         n_checks = 0;
    int         n_fail   = 0;

    param_matrix_mult_stream_if #(.DATA_W(8), .OUT_W(8))  bus_s ();
    param_matrix_mult_stream_if #(.DATA_W(8), .OUT_W(8))  bus_t ();
    param_matrix_mult_stream_if #(.DATA_W(8), .OUT_W(16)) bus_w ();

    assign bus_s.in_valid  = in_valid & ~sel;
    assign bus_t.in_valid  = in_valid & ~sel;
    assign bus_w.in_valid  = in_valid & sel;
    assign bus_s.in_data   = in_data;
    assign bus_t.in_data   = in_data;
    assign bus_w.in_data   = in_data;
    assign bus_s.out_ready = out_ready & ~sel;
    assign bus_t.out_ready = out_ready & ~sel;
    assign bus_w.out_ready = out_ready & sel;
    assign cur_in_ready    = sel ? bus_w.in_ready  : bus_s.in_ready;
    assign cur_out_valid   = sel ? bus_w.out_valid : bus_s.out_valid;

    param_matrix_mult_stream #(.N(3), .DATA_W(8), .OUT_W(8), .SATURATE(1)) dut_s (
        .clk(clk), .rst(rst), .bus(bus_s), .busy(busy_s), .ovf(ovf_s));
    param_matrix_mult_stream #(.N(3), .DATA_W(8), .OUT_W(8), .SATURATE(0)) dut_t (
        .clk(clk), .rst(rst), .bus(bus_t), .busy(busy_t), .ovf(ovf_t));
    param_matrix_mult_stream #(.N(4), .DATA_W(8), .OUT_W(16), .SATURATE(1)) dut_w (
        .clk(clk), .rst(rst), .bus(bus_w), .busy(busy_w), .ovf(ovf_w));

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: observed no end of test, expected end before 1 ms");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_ctrl(input string tag, input logic ir, input logic ov, input logic bz);
        if (sel) begin
            chk({tag, "/w.in_ready"},  32'(bus_w.in_ready),  32'(ir));
            chk({tag, "/w.out_valid"}, 32'(bus_w.out_valid), 32'(ov));
            chk({tag, "/w.busy"},      32'(busy_w),          32'(bz));
        end else begin
            chk({tag, "/s.in_ready"},  32'(bus_s.in_ready),  32'(ir));
            chk({tag, "/s.out_valid"}, 32'(bus_s.out_valid), 32'(ov));
            chk({tag, "/s.busy"},      32'(busy_s),          32'(bz));
            chk({tag, "/t.in_ready"},  32'(bus_t.in_ready),  32'(ir));
            chk({tag, "/t.out_valid"}, 32'(bus_t.out_valid), 32'(ov));
            chk({tag, "/t.busy"},      32'(busy_t),          32'(bz));
        end
    endtask

    task automatic chk_ovf(input string tag, input logic e);
        if (sel) begin
            chk({tag, "/w.ovf"}, 32'(ovf_w), 32'(e));
        end else begin
            chk({tag, "/s.ovf"}, 32'(ovf_s), 32'(e));
            chk({tag, "/t.ovf"}, 32'(ovf_t), 32'(e));
        end
    endtask

    // One full (or, with stop_at >= 0, partial) product: load, compute latency, drain.
    task automatic run_product(input int n, input int a[16], input int b[16],
                               input bit gaps, input bit bp, input int stop_at);
        int  nn   = n * n;
        int  maxv = (n == 4) ? 65535 : 255;
        int  c[16];
        bit  eovf = 1'b0;
        int  idx  = 0;
        int  cyc  = 0;
        int  got  = 0;
        bit  acc, hs;
        sel = (n == 4);
        for (int i = 0; i < n; i++)
            for (int j = 0; j < n; j++) begin
                c[i*n+j] = 0;
                for (int k = 0; k < n; k++) c[i*n+j] += a[i*n+k] * b[k*n+j];
                if (c[i*n+j] > maxv) eovf = 1'b1;
            end

        while (idx < 2*nn && cyc < 2000) begin
            in_valid = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
            in_data  = 8'((idx < nn) ? a[idx] : b[idx-nn]);
            chk_ctrl("load", 1'b1, 1'b0, 1'b0);
            acc = in_valid && cur_in_ready;
            @(posedge clk); #1;
            cyc++;
            if (acc) begin
                if (idx == 0) chk_ovf("ovf_clear", 1'b0);
                idx++;
            end
        end
        in_valid = 1'b0;
        if (idx != 2*nn) chk("load_timeout", 32'(idx), 32'(2*nn));

        chk_ctrl("compute_entry", 1'b0, 1'b0, 1'b1);
        for (int m = 1; m <= n*n*n + 1; m++) begin
            in_valid = 1'($urandom_range(0, 1));
            in_data  = 8'($urandom_range(0, 255));
            @(posedge clk); #1;
            if (m <= n*n*n) chk_ctrl("compute", 1'b0, 1'b0, 1'b1);
            else            chk_ctrl("first_out", 1'b0, 1'b1, 1'b1);
        end
        in_valid = 1'b0;

        cyc = 0;
        while (got < nn && got != stop_at && cyc < 2000) begin
            out_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
            if (sel) begin
                chk("w.out_data", 32'(bus_w.out_data), 32'((c[got] > 65535) ? 65535 : c[got]));
                chk("w.out_last", 32'(bus_w.out_last), 32'(got == nn-1));
            end else begin
                chk("s.out_data", 32'(bus_s.out_data), 32'((c[got] > 255) ? 255 : c[got]));
                chk("t.out_data", 32'(bus_t.out_data), 32'(c[got] % 256));
                chk("s.out_last", 32'(bus_s.out_last), 32'(got == nn-1));
                chk("t.out_last", 32'(bus_t.out_last), 32'(got == nn-1));
            end
            chk_ctrl("output", 1'b0, 1'b1, 1'b1);
            chk_ovf("ovf_out", eovf);
            hs = cur_out_valid && out_ready;
            @(posedge clk); #1;
            cyc++;
            if (hs) got++;
        end
        out_ready = 1'b0;
        if (got == nn) begin
            chk_ctrl("done", 1'b1, 1'b0, 1'b0);
            chk_ovf("ovf_hold", eovf);
        end else if (got != stop_at) begin
            chk("out_timeout", 32'(got), 32'(nn));
        end
    endtask

    initial begin
        int ma[16];
        int mb[16];
        int ones[16];

        for (int i = 0; i < 16; i++) ones[i] = 1;

        // Reset state of all three instances.
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        sel = 1'b0;
        chk_ctrl("reset", 1'b1, 1'b0, 1'b0);
        chk_ovf("reset", 1'b0);
        chk("reset/s.out_last", 32'(bus_s.out_last), 32'd0);
        chk("reset/t.out_last", 32'(bus_t.out_last), 32'd0);
        sel = 1'b1;
        chk_ctrl("reset", 1'b1, 1'b0, 1'b0);
        chk_ovf("reset", 1'b0);
        chk("reset/w.out_last", 32'(bus_w.out_last), 32'd0);

        // Identity times 1..9.
        for (int i = 0; i < 16; i++) begin
            ma[i] = (i < 9 && (i / 3) == (i % 3)) ? 1 : 0;
            mb[i] = i + 1;
        end
        run_product(3, ma, mb, 1'b0, 1'b0, -1);

        // All 0xFF: saturate to 255, truncate to 3, ovf in both.
        for (int i = 0; i < 16; i++) begin
            ma[i] = 255;
            mb[i] = 255;
        end
        run_product(3, ma, mb, 1'b0, 1'b1, -1);

        // Random operands with input gaps and output backpressure; one run small enough not to overflow.
        for (int r = 0; r < 4; r++) begin
            for (int i = 0; i < 16; i++) begin
                ma[i] = (r == 0) ? int'($urandom_range(0, 9)) : int'($urandom_range(0, 255));
                mb[i] = (r == 0) ? int'($urandom_range(0, 9)) : int'($urandom_range(0, 255));
            end
            run_product(3, ma, mb, 1'b1, 1'b1, -1);
        end

        // Reset after 5 accepted elements, then a clean all-ones product.
        sel      = 1'b0;
        in_valid = 1'b1;
        in_data  = 8'd7;
        repeat (5) @(posedge clk);
        #1;
        in_valid = 1'b0;
        rst      = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk_ctrl("rst_load", 1'b1, 1'b0, 1'b0);
        chk_ovf("rst_load", 1'b0);
        run_product(3, ones, ones, 1'b0, 1'b0, -1);

        // Reset in the middle of OUTPUT, then another clean product.
        for (int i = 0; i < 16; i++) begin
            ma[i] = 255;
            mb[i] = 255;
        end
        run_product(3, ma, mb, 1'b0, 1'b1, 4);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk_ctrl("rst_out", 1'b1, 1'b0, 1'b0);
        chk_ovf("rst_out", 1'b0);
        run_product(3, ones, ones, 1'b0, 1'b0, -1);

        // N=4, 16-bit output: all 1 times all 2, then a random product back to back.
        for (int i = 0; i < 16; i++) mb[i] = 2;
        run_product(4, ones, mb, 1'b0, 1'b0, -1);
        for (int i = 0; i < 16; i++) begin
            ma[i] = int'($urandom_range(0, 255));
            mb[i] = int'($urandom_range(0, 255));
        end
        run_product(4, ma, mb, 1'b1, 1'b1, -1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
